// File: rtl/sram_bist_pkg.sv
// Shared types for the March C- SRAM BIST: controller states and the march
// element table (direction, op count, read/write and data polarity per op).
package sram_bist_pkg;

  localparam int ELEM_COUNT = 6;
  localparam int ELEM_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Bit [i] of is_read/pol describes op i of the element; pol=1 means ~P.
  typedef struct packed {
    logic       down;
    logic       two_ops;
    logic [1:0] is_read;
    logic [1:0] pol;
  } march_elem_t;

  function automatic march_elem_t march_elem(input logic [ELEM_W-1:0] idx);
    march_elem_t m;
    m = '{down: 1'b0, two_ops: 1'b0, is_read: 2'b00, pol: 2'b00};  // M0 up(w0)
    case (idx)
      3'd1: m = '{down: 1'b0, two_ops: 1'b1, is_read: 2'b01, pol: 2'b10};  // up(r0,w1)
      3'd2: m = '{down: 1'b0, two_ops: 1'b1, is_read: 2'b01, pol: 2'b01};  // up(r1,w0)
      3'd3: m = '{down: 1'b1, two_ops: 1'b1, is_read: 2'b01, pol: 2'b10};  // down(r0,w1)
      3'd4: m = '{down: 1'b1, two_ops: 1'b1, is_read: 2'b01, pol: 2'b01};  // down(r1,w0)
      3'd5: m = '{down: 1'b0, two_ops: 1'b0, is_read: 2'b01, pol: 2'b00};  // up(r0)
      default: ;
    endcase
    return m;
  endfunction

  function automatic logic elem_down(input logic [ELEM_W-1:0] idx);
    march_elem_t m;
    m = march_elem(idx);
    return m.down;
  endfunction

  function automatic logic elem_two_ops(input logic [ELEM_W-1:0] idx);
    march_elem_t m;
    m = march_elem(idx);
    return m.two_ops;
  endfunction

  function automatic logic elem_is_read(input logic [ELEM_W-1:0] idx, input logic op);
    march_elem_t m;
    m = march_elem(idx);
    return m.is_read[op];
  endfunction

  function automatic logic elem_pol(input logic [ELEM_W-1:0] idx, input logic op);
    march_elem_t m;
    m = march_elem(idx);
    return m.pol[op];
  endfunction

endpackage

// File: rtl/sram_march_addr_gen.sv
// March sequencer: holds the element/address/op of the op currently being
// driven and exposes the following op so the top can register it directly.
module sram_march_addr_gen
  import sram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  init,
  input  logic                  step,
  output logic [ELEM_W-1:0]     elem,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  op,
  output logic                  last,
  output logic [ELEM_W-1:0]     next_elem,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  next_op
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

  logic                  cur_down;
  logic                  cur_two;
  logic [ADDR_WIDTH-1:0] end_addr;
  logic                  at_end;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cur_down  = elem_down(elem);
    cur_two   = elem_two_ops(elem);
    end_addr  = cur_down ? '0 : ADDR_MAX;
    at_end    = (addr == end_addr);
    next_elem = elem;
    next_addr = addr;
    next_op   = 1'b0;
    if (cur_two && !op) begin
      next_op = 1'b1;
    end else if (at_end) begin
      next_elem = elem + 3'd1;
      next_addr = elem_down(elem + 3'd1) ? ADDR_MAX : '0;
    end else begin
      next_addr = cur_down ? addr - 1'b1 : addr + 1'b1;
    end
    last = (elem == ELEM_W'(ELEM_COUNT - 1)) && at_end && (op == cur_two);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstb || init) begin
      elem <= '0;
      addr <= '0;
      op   <= 1'b0;
    end else if (step) begin
      elem <= next_elem;
      addr <= next_addr;
      op   <= next_op;
    end
  end

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller: drives one SRAM op per cycle, compares read data
// one cycle after each read edge and records the first mismatch.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   start,
  input  logic                   stop_on_fail,
  input  logic [DATA_WIDTH-1:0]  pattern,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [7:0]             fail_count,
  output logic [2:0]             fail_element,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic [DATA_WIDTH-1:0]  fail_data,
  output logic [DATA_WIDTH-1:0]  fail_expected,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout,
  input  logic                   sram_sae_int,
  output logic                   sram_sae_muxed
);

  localparam logic [WMASK_WIDTH-1:0] WMASK_ONES = {WMASK_WIDTH{1'b1}};

  state_t                state;
  logic [DATA_WIDTH-1:0] pat_q;
  logic                  pend_valid;
  logic [DATA_WIDTH-1:0] pend_exp;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [ELEM_W-1:0]     pend_elem;

  logic [ELEM_W-1:0]     g_elem, n_elem;
  logic [ADDR_WIDTH-1:0] g_addr, n_addr;
  logic                  g_op, n_op, g_last;

  logic                  accept, mismatch, halt, gen_step;
  logic                  cur_read, nxt_write;
  logic [DATA_WIDTH-1:0] cur_word, nxt_word;

  assign sram_sae_muxed = sram_sae_int;

  always_comb begin
    accept    = start && (state == ST_IDLE || state == ST_DONE);
    mismatch  = pend_valid && (sram_dout != pend_exp);
    halt      = mismatch && stop_on_fail;
    gen_step  = (state == ST_RUN) && !halt && !g_last;
    cur_read  = elem_is_read(g_elem, g_op);
    cur_word  = elem_pol(g_elem, g_op) ? ~pat_q : pat_q;
    nxt_write = !elem_is_read(n_elem, n_op);
    nxt_word  = elem_pol(n_elem, n_op) ? ~pat_q : pat_q;
  end

  sram_march_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rstb      (rstb),
    .init      (accept),
    .step      (gen_step),
    .elem      (g_elem),
    .addr      (g_addr),
    .op        (g_op),
    .last      (g_last),
    .next_elem (n_elem),
    .next_addr (n_addr),
    .next_op   (n_op)
  );

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      fail          <= 1'b0;
      fail_count    <= '0;
      fail_element  <= '0;
      fail_addr     <= '0;
      fail_data     <= '0;
      fail_expected <= '0;
      sram_we       <= 1'b0;
      sram_wmask    <= '0;
      sram_addr     <= '0;
      sram_din      <= '0;
      pat_q         <= '0;
      pend_valid    <= 1'b0;
      pend_exp      <= '0;
      pend_addr     <= '0;
      pend_elem     <= '0;
    end else begin
      // Only RUN/DRAIN can hold a pending compare, so this never races the clear on accept.
      if (mismatch) begin
        fail <= 1'b1;
        if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
        if (!fail) begin
          fail_element  <= pend_elem;
          fail_addr     <= pend_addr;
          fail_data     <= sram_dout;
          fail_expected <= pend_exp;
        end
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state         <= ST_RUN;
            busy          <= 1'b1;
            done          <= 1'b0;
            fail          <= 1'b0;
            fail_count    <= '0;
            fail_element  <= '0;
            fail_addr     <= '0;
            fail_data     <= '0;
            fail_expected <= '0;
            pat_q         <= pattern;
            sram_we       <= 1'b1;
            sram_wmask    <= WMASK_ONES;
            sram_addr     <= '0;
            sram_din      <= pattern;
            pend_valid    <= 1'b0;
          end
        end

        ST_RUN, ST_DRAIN: begin
          if (state == ST_DRAIN || halt) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            pend_valid <= 1'b0;
            sram_we    <= 1'b0;
            sram_wmask <= '0;
            sram_addr  <= '0;
            sram_din   <= '0;
          end else begin
            // The op on the bus now is sampled by the SRAM at this edge; queue its compare.
            pend_valid <= cur_read;
            pend_exp   <= cur_word;
            pend_addr  <= g_addr;
            pend_elem  <= g_elem;
            if (g_last) begin
              state      <= ST_DRAIN;
              sram_we    <= 1'b0;
              sram_wmask <= '0;
              sram_addr  <= '0;
              sram_din   <= '0;
            end else begin
              sram_we    <= nxt_write;
              sram_wmask <= nxt_write ? WMASK_ONES : '0;
              sram_addr  <= n_addr;
              sram_din   <= nxt_write ? nxt_word : '0;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Self-checking bench for sram_march_bist: table-driven runs against a
// behavioural SRAM with optional stuck-at-1 bits, plus an op-stream scoreboard.
module tb_sram_march_bist;

  localparam int DW    = 24;
  localparam int AW    = 6;
  localparam int WW    = 1;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rstb, start, stop_on_fail;
  logic [DW-1:0] pattern;
  logic          busy, done, fail;
  logic [7:0]    fail_count;
  logic [2:0]    fail_element;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data, fail_expected;
  logic          sram_we;
  logic [WW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;
  logic          sram_sae_int, sram_sae_muxed;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(WW)) dut (
    .clk            (clk),
    .rstb           (rstb),
    .start          (start),
    .stop_on_fail   (stop_on_fail),
    .pattern        (pattern),
    .busy           (busy),
    .done           (done),
    .fail           (fail),
    .fail_count     (fail_count),
    .fail_element   (fail_element),
    .fail_addr      (fail_addr),
    .fail_data      (fail_data),
    .fail_expected  (fail_expected),
    .sram_we        (sram_we),
    .sram_wmask     (sram_wmask),
    .sram_addr      (sram_addr),
    .sram_din       (sram_din),
    .sram_dout      (sram_dout),
    .sram_sae_int   (sram_sae_int),
    .sram_sae_muxed (sram_sae_muxed)
  );

  // Behavioural SRAM: bits in fault_mask read back as 1 at fault_addr.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] fault_addr;
  logic [DW-1:0] fault_mask;
  logic          scramble;

  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'($urandom);
    end else if (sram_we && sram_wmask[0]) begin
      mem[sram_addr] <= sram_din | ((sram_addr == fault_addr) ? fault_mask : '0);
    end
    sram_dout <= mem[sram_addr] | ((sram_addr == fault_addr) ? fault_mask : '0);
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  op_t exp_q[$];

  typedef struct {
    logic [DW-1:0] pattern;
    logic          stop;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_mask;
    int            edges;
    logic          fail;
    logic [7:0]    count;
    logic [2:0]    elem;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] expv;
    bit            chk_mem;
    logic [DW-1:0] mem_word;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Independent March C- op list: kind 0=w P, 1=w ~P, 2=r P, 3=r ~P.
  task automatic build_ops(input logic [DW-1:0] p);
    int nops[6]    = '{1, 2, 2, 2, 2, 1};
    bit down[6]    = '{0, 0, 0, 1, 1, 0};
    int kind[6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 0}};
    op_t o;
    exp_q.delete();
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < DEPTH; i++)
        for (int k = 0; k < nops[e]; k++) begin
          o.we   = (kind[e][k] < 2);
          o.addr = AW'(down[e] ? DEPTH - 1 - i : i);
          o.data = kind[e][k][0] ? ~p : p;
          exp_q.push_back(o);
        end
  endtask

  task automatic run_test(input vec_t v, input int poke_at, input int reset_at, output int edges);
    op_t e;
    bit  seen;
    seen  = 0;
    edges = -1;
    @(negedge clk);
    fault_addr   = v.f_addr;
    fault_mask   = v.f_mask;
    pattern      = v.pattern;
    stop_on_fail = v.stop;
    scramble     = 1'b1;
    @(negedge clk);
    scramble = 1'b0;
    start    = 1'b1;
    build_ops(v.pattern);
    @(negedge clk);
    start = 1'b0;
    check("start_state", {busy, done, fail, fail_count}, {3'b100, 8'd0});
    check("start_capture_clr", {fail_element, fail_addr, fail_data, fail_expected}, '0);
    for (int k = 0; k < 3000; k++) begin
      if (k > 0) @(negedge clk);
      if (reset_at >= 0 && k == reset_at) begin
        check("reset_mid_run", {sram_we, busy, done, fail, sram_addr}, '0);
        rstb = 1'b1;
        return;
      end
      if (done) begin
        edges = k;
        seen  = 1;
        break;
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("op%0d", k),
              {sram_we, sram_wmask, sram_addr, (sram_we ? sram_din : DW'(0))},
              {e.we, WW'(e.we), e.addr, (e.we ? e.data : DW'(0))});
      end else begin
        check("drain_cycle", {sram_we, sram_wmask, busy}, {1'b0, WW'(0), 1'b1});
      end
      start = (k == poke_at);
      if (reset_at >= 0 && k == reset_at - 1) rstb = 1'b0;
    end
    check("done_reached", seen, 1'b1);
  endtask

  task automatic check_result(input vec_t v, input int edges);
    int bad;
    check("done_edges", edges, v.edges);
    check("fail_flag", {fail, busy}, {v.fail, 1'b0});
    check("fail_count", fail_count, v.count);
    check("fail_capture", {fail_element, fail_addr, fail_data, fail_expected},
          {v.elem, v.addr, v.data, v.expv});
    if (!v.stop) check("queue_drained", exp_q.size(), 0);
    if (v.chk_mem) begin
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== v.mem_word) bad++;
      check("final_mem", bad, 0);
    end
    repeat (3) begin
      @(negedge clk);
      check("done_hold_no_we", {done, busy, sram_we, sram_wmask}, {3'b100, WW'(0)});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    vecs[0] = '{pattern: 24'h000000, stop: 0, f_addr: 0, f_mask: 0, edges: 641, fail: 0,
                count: 0, elem: 0, addr: 0, data: 0, expv: 0, chk_mem: 1, mem_word: 24'h000000};
    vecs[1] = '{pattern: 24'hA5A5A5, stop: 0, f_addr: 0, f_mask: 0, edges: 641, fail: 0,
                count: 0, elem: 0, addr: 0, data: 0, expv: 0, chk_mem: 1, mem_word: 24'hA5A5A5};
    vecs[2] = '{pattern: 24'h000000, stop: 0, f_addr: 17, f_mask: 24'h000020, edges: 641, fail: 1,
                count: 3, elem: 1, addr: 17, data: 24'h000020, expv: 24'h000000, chk_mem: 0, mem_word: 0};
    vecs[3] = '{pattern: 24'h000000, stop: 1, f_addr: 17, f_mask: 24'h000020, edges: 100, fail: 1,
                count: 1, elem: 1, addr: 17, data: 24'h000020, expv: 24'h000000, chk_mem: 0, mem_word: 0};
    vecs[4] = '{pattern: 24'hFFFFFF, stop: 0, f_addr: 17, f_mask: 24'h000020, edges: 641, fail: 1,
                count: 2, elem: 2, addr: 17, data: 24'h000020, expv: 24'h000000, chk_mem: 0, mem_word: 0};

    rstb = 1'b0; start = 1'b0; stop_on_fail = 1'b0; pattern = '0;
    sram_sae_int = 1'b0; fault_addr = '0; fault_mask = '0; scramble = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, fail, sram_we, sram_wmask, fail_count}, '0);
    check("reset_bus", {sram_addr, sram_din, fail_element, fail_addr, fail_data, fail_expected}, '0);
    rstb = 1'b1;
    @(negedge clk);
    check("idle_hold", {busy, done, sram_we}, 3'b000);

    sram_sae_int = 1'b1;
    #1 check("sae_high", sram_sae_muxed, 1'b1);
    sram_sae_int = 1'b0;
    #1 check("sae_low", sram_sae_muxed, 1'b0);

    for (int i = 0; i < 5; i++) begin
      run_test(vecs[i], -1, -1, edges);
      check_result(vecs[i], edges);
    end

    // start pulsed at edge 200 while busy must be ignored.
    run_test(vecs[0], 199, -1, edges);
    check_result(vecs[0], edges);

    // Reset asserted at edge 300 abandons the run; the controller recovers from IDLE.
    run_test(vecs[1], -1, 300, edges);
    repeat (2) begin
      @(negedge clk);
      check("post_reset_idle", {busy, done, fail, sram_we}, 4'b0000);
    end
    run_test(vecs[1], -1, -1, edges);
    check_result(vecs[1], edges);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
